sobel_sequencer: RTL and testbench

SOBEL_SEQUENCER -- requirements
Module: sobel_sequencer

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_sequencer_if.sv | 38 +++
 rtl/window_counter.sv | 50 +++++
 rtl/sobel_sequencer.sv | 109 ++++++++++
 tb/tb_sobel_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window sequencer.
package sobel_pkg;

  localparam int COORD_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD9,
    SHIFT,
    READ3,
    CALC,
    WRITE,
    ADVANCE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sobel_sequencer_if.sv
// Command/strobe bundle between the Sobel sequencer and its datapath/host.
interface sobel_sequencer_if
  import sobel_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) ();

  logic               start;
  logic               abort;
  logic               load_done;
  logic               shift_done;
  logic               read_done;
  logic               calc_done;
  logic               write_done;
  logic               start_9_read;
  logic               start_shift;
  logic               start_read;
  logic               start_calc;
  logic               start_write;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic [COORD_W-1:0] out_addr;
  logic               busy;
  logic               all_done;

  modport slave (
    input  start, abort, load_done, shift_done, read_done, calc_done, write_done,
    output start_9_read, start_shift, start_read, start_calc, start_write,
           win_row, win_col, out_addr, busy, all_done
  );

  modport master (
    output start, abort, load_done, shift_done, read_done, calc_done, write_done,
    input  start_9_read, start_shift, start_read, start_calc, start_write,
           win_row, win_col, out_addr, busy, all_done
  );

endinterface

// File: rtl/window_counter.sv
// Window centre coordinates and linear output address; the address is a plain
// incrementer so no multiplier is needed.
module window_counter
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               init,
  input  logic               step,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic [COORD_W-1:0] out_addr,
  output logic               last_col,
  output logic               last_row
);

  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 2);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

  assign last_col = (win_col == COL_MAX);
  assign last_row = (win_row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_row  <= '0;
      win_col  <= '0;
      out_addr <= '0;
    end else if (init) begin
      win_row  <= ONE;
      win_col  <= ONE;
      out_addr <= '0;
    end else if (step) begin
      out_addr <= out_addr + ONE;
      // Coordinates saturate on the final window instead of wrapping.
      if (!last_col) begin
        win_col <= win_col + ONE;
      end else if (!last_row) begin
        win_col <= ONE;
        win_row <= win_row + ONE;
      end
    end
  end

endmodule

// File: rtl/sobel_sequencer.sv
// Full-frame 3x3 Sobel window sequencer: issues load/shift/read/calc/write
// commands per window and waits on the datapath completion strobes.
module sobel_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sobel_sequencer_if.slave   bus
);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic               cnt_clear;
  logic               cnt_init;
  logic               cnt_step;
  logic               last_col;
  logic               last_row;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic [COORD_W-1:0] out_addr;

  window_counter #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .COORD_W (COORD_W)
  ) u_window_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .init     (cnt_init),
    .step     (cnt_step),
    .win_row  (win_row),
    .win_col  (win_col),
    .out_addr (out_addr),
    .last_col (last_col),
    .last_row (last_row)
  );

  assign bus.win_row  = win_row;
  assign bus.win_col  = win_col;
  assign bus.out_addr = out_addr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_init  = 1'b0;
    cnt_step  = 1'b0;
    // Abort beats start in IDLE as well as ending a pass in flight.
    if (bus.abort) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) begin
                   state_d  = LOAD9;
                   cnt_init = 1'b1;
                 end
        LOAD9:   if (bus.load_done)  state_d = CALC;
        SHIFT:   if (bus.shift_done) state_d = READ3;
        READ3:   if (bus.read_done)  state_d = CALC;
        CALC:    if (bus.calc_done)  state_d = WRITE;
        WRITE:   if (bus.write_done) state_d = ADVANCE;
        ADVANCE: begin
                   cnt_step = 1'b1;
                   if (!last_col)      state_d = SHIFT;
                   else if (!last_row) state_d = LOAD9;
                   else                state_d = DONE;
                 end
        DONE:    begin
                   state_d   = IDLE;
                   cnt_clear = 1'b1;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse lines up with
  // the first cycle of its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.start_9_read <= 1'b0;
      bus.start_shift  <= 1'b0;
      bus.start_read   <= 1'b0;
      bus.start_calc   <= 1'b0;
      bus.start_write  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.all_done     <= 1'b0;
    end else begin
      bus.start_9_read <= (state_d == LOAD9) && (state_q != LOAD9);
      bus.start_shift  <= (state_d == SHIFT) && (state_q != SHIFT);
      bus.start_read   <= (state_d == READ3) && (state_q != READ3);
      bus.start_calc   <= (state_d == CALC)  && (state_q != CALC);
      bus.start_write  <= (state_d == WRITE) && (state_q != WRITE);
      bus.busy         <= (state_d != IDLE);
      bus.all_done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_sobel_sequencer.sv
// Self-checking bench for sobel_sequencer on a 5x5 frame with randomized
// done-strobe latencies against a nested-loop window model.
module tb_sobel_sequencer;

  localparam int W = 5;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  sobel_sequencer_if #(.COORD_W(16)) sif ();

  sobel_sequencer #(.IMG_W(W), .IMG_H(H), .COORD_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] pulses();
    return {sif.start_write, sif.start_calc, sif.start_read, sif.start_shift, sif.start_9_read};
  endfunction

  function automatic logic [31:0] mk_ev(input int kind, input int row, input int col, input int addr);
    return {8'(kind), 8'(row), 8'(col), 8'(addr)};
  endfunction

  // Kinds: 0 load9, 1 shift, 2 read, 3 calc, 4 write.
  task automatic build_expected();
    int addr;
    exp_q.delete();
    addr = 0;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        if (c == 1) exp_q.push_back(mk_ev(0, r, c, addr));
        else begin
          exp_q.push_back(mk_ev(1, r, c, addr));
          exp_q.push_back(mk_ev(2, r, c, addr));
        end
        exp_q.push_back(mk_ev(3, r, c, addr));
        exp_q.push_back(mk_ev(4, r, c, addr));
        addr++;
      end
    end
  endtask

  task automatic clear_inputs();
    sif.start      = 1'b0;
    sif.abort      = 1'b0;
    sif.load_done  = 1'b0;
    sif.shift_done = 1'b0;
    sif.read_done  = 1'b0;
    sif.calc_done  = 1'b0;
    sif.write_done = 1'b0;
  endtask

  task automatic drive_done(input int kind);
    case (kind)
      0: sif.load_done  = 1'b1;
      1: sif.shift_done = 1'b1;
      2: sif.read_done  = 1'b1;
      3: sif.calc_done  = 1'b1;
      default: sif.write_done = 1'b1;
    endcase
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pulses"}, {25'd0, sif.busy, sif.all_done, pulses()}, 32'd0);
    chk({tag, "_coords"}, {sif.win_row[7:0], sif.win_col[7:0], sif.out_addr[15:0]}, 32'd0);
  endtask

  // brk_act: 0 run to completion, 1 abort at the break pulse, 2 reset there.
  task automatic run_seq(input int dmin, input int dmax, input bit inject,
                         input int brk_kind, input int brk_row, input int brk_col,
                         input int brk_act);
    int pend_kind, pend_cnt, cyc, n_done, n_wdone, nexp, late_pulses, brk_idx;
    bit pend, fin, broke, injected, restarted;
    logic [4:0] p;
    got_q.delete();
    build_expected();
    pend = 0; pend_kind = 0; pend_cnt = 0; fin = 0; broke = 0;
    injected = 0; restarted = 0; cyc = 0; n_done = 0; n_wdone = 0;
    @(negedge clk);
    sif.start = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      clear_inputs();
      p = pulses();
      if (sif.all_done) begin
        n_done++;
        chk("done_after_last_write", 32'(n_wdone), 32'(9));
        chk("busy_in_done", {31'd0, sif.busy}, 32'd1);
      end else if (n_done > 0) begin
        chk("busy_after_done", {31'd0, sif.busy}, 32'd0);
        fin = 1;
      end
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          got_q.push_back(mk_ev(k, int'(sif.win_row), int'(sif.win_col), int'(sif.out_addr)));
          if (brk_act != 0 && k == brk_kind && int'(sif.win_row) == brk_row &&
              int'(sif.win_col) == brk_col) broke = 1;
          else begin
            pend = 1;
            pend_kind = k;
            pend_cnt = int'($urandom_range(dmax, dmin));
          end
        end
      end
      if (broke) begin
        if (brk_act == 1) sif.abort = 1'b1;
        else rst = 1'b1;
        fin = 1;
      end else begin
        if (inject && !injected && p[4]) begin
          sif.calc_done = 1'b1;
          injected = 1;
        end
        if (inject && !restarted && got_q.size() == 6) begin
          sif.start = 1'b1;
          restarted = 1;
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            drive_done(pend_kind);
            if (pend_kind == 4) n_wdone++;
            pend = 0;
          end else pend_cnt--;
        end
      end
    end
    chk("timeout", {31'd0, fin}, 32'd1);
    if (broke) begin
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      chk_idle_outputs(brk_act == 1 ? "abort" : "midrst");
      late_pulses = 0;
      repeat (10) begin
        @(negedge clk);
        if (pulses() != 5'd0 || sif.all_done) late_pulses++;
      end
      chk("no_activity_after_break", 32'(late_pulses), 32'd0);
      brk_idx = exp_q.size() - 1;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i] == mk_ev(brk_kind, brk_row, brk_col, 0) ||
            exp_q[i][31:8] == mk_ev(brk_kind, brk_row, brk_col, 0) >> 8) brk_idx = i;
      nexp = brk_idx + 1;
    end else begin
      chk("all_done_count", 32'(n_done), 32'd1);
      nexp = exp_q.size();
    end
    chk("event_count", 32'(got_q.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < got_q.size(); i++)
      chk($sformatf("event_%0d", i), got_q[i], exp_q[i]);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    @(negedge clk);
    sif.start = 1'b1;
    sif.abort = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk_idle_outputs("start_abort_idle");

    run_seq(1, 1, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    run_seq(5, 5, 1'b0, 0, 0, 0, 0);
    run_seq(1, 4, 1'b1, 0, 0, 0, 0);
    run_seq(1, 2, 1'b0, 3, 2, 2, 1);
    run_seq(1, 1, 1'b0, 2, 1, 3, 2);
    run_seq(0, 3, 1'b0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
